// File: rtl/arith_pipe_hs_if.sv
// Operand/result stream bundle for arith_pipe_hs: upstream beat, downstream
// result and the ready/valid pair on each side.
interface arith_pipe_hs_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Y;
  logic         co;
  logic         ovf;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, Y, co, ovf
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, Y, co, ovf
  );
endinterface

// File: rtl/arith_pipe_hs.sv
// Signed N-bit two-operand ALU, PIPE register stages, valid/ready on both
// sides with a global stall, optional ADD/SUB saturation and a sync flush.
module arith_pipe_hs #(
  parameter int N    = 16,
  parameter int PIPE = 2,
  parameter bit SAT  = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  arith_pipe_hs_if.slave bus
);
  localparam int SW = $clog2(N);

  typedef struct packed {
    logic [N-1:0] y;
    logic         co;
    logic         ovf;
  } res_t;

  logic         stall, en, sub;
  logic [N-1:0] a, b, b_eff;
  logic [N:0]   sum;
  logic [SW-1:0] shamt;
  res_t         res;
  res_t         st [1:PIPE];
  logic [PIPE:1] vld_pipe;

  assign a     = bus.A;
  assign b     = bus.B;
  assign shamt = b[SW-1:0];

  // SUB shares the adder as A + ~B + 1 so co is the no-borrow flag.
  assign sub   = (bus.opcode == 3'b001);
  assign b_eff = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};

  always_comb begin
    res = '0;
    case (bus.opcode)
      3'b000, 3'b001: begin
        res.y   = sum[N-1:0];
        res.co  = sum[N];
        res.ovf = (sub ? (a[N-1] != b[N-1]) : (a[N-1] == b[N-1])) &&
                  (sum[N-1] != a[N-1]);
        if (SAT && res.ovf)
          res.y = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
      3'b010:  res.y = a & b;
      3'b011:  res.y = a | b;
      3'b100:  res.y = a ^ b;
      3'b101:  res.y = ~a;
      3'b110:  res.y = a << shamt;
      3'b111:  res.y = $signed(a) >>> shamt;
      default: res = '0;
    endcase
  end

  // A held output blocks every stage; bubbles move like data otherwise.
  assign stall        = vld_pipe[PIPE] & ~bus.out_ready;
  assign en           = ~stall;
  assign bus.in_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int k = 1; k <= PIPE; k++) st[k] <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe[1] <= bus.in_valid;
      if (bus.in_valid) st[1] <= res;
      for (int k = 2; k <= PIPE; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        st[k]       <= st[k-1];
      end
    end
  end

  assign bus.out_valid = vld_pipe[PIPE];
  assign bus.Y         = st[PIPE].y;
  assign bus.co        = st[PIPE].co;
  assign bus.ovf       = st[PIPE].ovf;
endmodule

// File: tb/tb_arith_pipe_hs.sv
// Randomized scoreboard bench for arith_pipe_hs (wrap and saturating
// instances side by side) plus directed latency/stall/flush/reset checks.
module tb_arith_pipe_hs;
  localparam int N    = 16;
  localparam int PIPE = 2;
  localparam int SW   = $clog2(N);
  localparam longint MAXV = (longint'(1) << (N-1)) - 1;
  localparam longint MINV = -(longint'(1) << (N-1));

  typedef struct packed {
    logic [N-1:0] y;
    logic         co;
    logic         ovf;
  } res_t;
  typedef struct {
    res_t w;
    res_t s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic rand_en = 1'b0;
  logic dir_rdy = 1'b1;
  logic rnd_rdy = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  logic prev_stall = 1'b0;
  logic [N-1:0] prev_y = '0;

  always #5 clk = ~clk;

  arith_pipe_hs_if #(.N(N)) bw ();
  arith_pipe_hs_if #(.N(N)) bs ();

  arith_pipe_hs #(.N(N), .PIPE(PIPE), .SAT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bw.slave));
  arith_pipe_hs #(.N(N), .PIPE(PIPE), .SAT(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bs.slave));

  assign bw.out_ready = rand_en ? rnd_rdy : dir_rdy;
  assign bs.out_ready = bw.out_ready;
  assign bs.in_valid  = bw.in_valid;
  assign bs.A         = bw.A;
  assign bs.B         = bw.B;
  assign bs.opcode    = bw.opcode;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on sign/zero-extended operands.
  function automatic res_t model(logic [N-1:0] a, logic [N-1:0] b,
                                 logic [2:0] op, bit sat);
    longint sa, sb, ua, ub, s;
    int sh;
    res_t r;
    r  = '0;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    sh = int'(b[SW-1:0]);
    case (op)
      3'd0, 3'd1: begin
        s     = (op == 3'd0) ? sa + sb : sa - sb;
        r.co  = (op == 3'd0) ? (ua + ub >= (longint'(1) << N)) : (ua >= ub);
        r.ovf = (s > MAXV) || (s < MINV);
        r.y   = N'(s);
        if (sat && r.ovf) r.y = (s > 0) ? N'(MAXV) : N'(MINV);
      end
      3'd2: r.y = a & b;
      3'd3: r.y = a | b;
      3'd4: r.y = a ^ b;
      3'd5: r.y = ~a;
      3'd6: r.y = N'(ua << sh);
      default: r.y = N'(sa >>> sh);
    endcase
    return r;
  endfunction

  always #1 ;

  always @(posedge clk) begin
    #1 rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: sampled mid-cycle, the same view the next rising edge uses.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bw.out_valid, 1);
        chk("hold_y", bw.Y, prev_y);
      end
      if (bw.out_valid && bw.out_ready) begin
        if (q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = q.pop_front();
          chk("sb_y",     bw.Y,   e.w.y);
          chk("sb_co",    bw.co,  e.w.co);
          chk("sb_ovf",   bw.ovf, e.w.ovf);
          chk("sb_sat_v", bs.out_valid, 1);
          chk("sb_sat_y", bs.Y,   e.s.y);
          chk("sb_sat_o", bs.ovf, e.s.ovf);
        end
      end
      if (bw.in_valid && bw.in_ready) begin
        e.w = model(bw.A, bw.B, bw.opcode, 1'b0);
        e.s = model(bw.A, bw.B, bw.opcode, 1'b1);
        q.push_back(e);
      end
      prev_stall = bw.out_valid && !bw.out_ready;
      prev_y     = bw.Y;
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(logic [N-1:0] a, logic [N-1:0] b, logic [2:0] op);
    int t = 0;
    bw.in_valid = 1'b1;
    bw.A = a;
    bw.B = b;
    bw.opcode = op;
    do begin
      @(negedge clk);
      t++;
    end while (!bw.in_ready && t < 500);
    if (t >= 500) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 bw.in_valid = 1'b0;
  endtask

  // Single beat into an empty pipe with out_ready=1: result after PIPE edges.
  task automatic lat(string tag, logic [N-1:0] a, logic [N-1:0] b, logic [2:0] op);
    send(a, b, op);
    repeat (PIPE - 1) begin
      chk({tag, "_early"}, bw.out_valid, 0);
      @(posedge clk);
      #1;
    end
    chk({tag, "_valid"}, bw.out_valid, 1);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bw.in_valid = 1'b0;
    bw.A = '0;
    bw.B = '0;
    bw.opcode = '0;
    #12;
    chk("rst_valid", bw.out_valid, 0);
    chk("rst_y",     bw.Y, 0);
    chk("rst_co",    bw.co, 0);
    chk("rst_ovf",   bw.ovf, 0);
    chk("rst_ready", bw.in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    lat("add", 16'd100, -16'sd30, 3'd0);
    chk("add_y", bw.Y, 16'd70);
    chk("add_co", bw.co, 1);
    chk("add_ovf", bw.ovf, 0);
    idle(2);

    lat("addovf", 16'h7FFF, 16'h0001, 3'd0);
    chk("addovf_y", bw.Y, 16'h8000);
    chk("addovf_o", bw.ovf, 1);
    chk("addovf_co", bw.co, 0);
    chk("addsat_y", bs.Y, 16'h7FFF);
    chk("addsat_o", bs.ovf, 1);
    idle(2);

    lat("subsat", 16'h8000, 16'h0001, 3'd1);
    chk("subsat_y", bs.Y, 16'h8000);
    chk("subsat_o", bs.ovf, 1);
    chk("subsat_co", bs.co, 1);
    idle(2);

    lat("asr", -16'sd16, 16'd2, 3'd7);
    chk("asr_y", bw.Y, 16'hFFFC);
    chk("asr_co", bw.co, 0);
    chk("asr_ovf", bw.ovf, 0);
    idle(2);

    fork
      begin
        for (int i = 1; i <= 4; i++) send(N'(i), N'(i), 3'd0);
      end
      begin
        repeat (PIPE) @(posedge clk);
        #1 dir_rdy = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", bw.in_ready, 0);
          chk("bp_y", bw.Y, 16'd2);
          @(posedge clk);
          #1;
        end
        dir_rdy = 1'b1;
      end
    join
    idle(PIPE + 3);
    chk("bp_drain", q.size(), 0);

    send(16'd5, 16'd5, 3'd0);
    send(16'd6, 16'd6, 3'd0);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    chk("flush_valid", bw.out_valid, 0);
    idle(1);
    chk("flush_gone", bw.out_valid, 0);
    lat("postflush", 16'd9, 16'd3, 3'd1);
    chk("postflush_y", bw.Y, 16'd6);
    idle(2);

    send(16'd7, 16'd7, 3'd0);
    send(16'd8, 16'd8, 3'd0);
    chk("rst_pre_valid", bw.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bw.out_valid, 0);
    chk("arst_y",     bw.Y, 0);
    chk("arst_co",    bw.co, 0);
    chk("arst_ovf",   bw.ovf, 0);
    chk("arst_ready", bw.in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lat("postrst", 16'h00F0, 16'h0F0F, 3'd4);
    chk("postrst_y", bw.Y, 16'h0FFF);
    idle(2);

    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] ra, rb;
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: ra = 16'h0001;
        2: ra = '1;
        3: ra = 16'h7FFF;
        4: ra = 16'h8000;
        default: ra = N'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 16'h0001;
        2: rb = '1;
        3: rb = 16'h7FFF;
        4: rb = 16'h8000;
        default: rb = N'($urandom);
      endcase
      send(ra, rb, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rand_en = 1'b0;
    idle(PIPE + 6);
    chk("rand_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/arith_pipe_hs.md
Name: arith_pipe_hs

Overview:
- Parametrised successor to the fixed-opcode pipelined arithmetic datapath.
- Signed N-bit two-operand ALU with configurable pipeline depth PIPE, valid/ready handshake on both sides, and backpressure stall.
- Adds optional saturation, a signed-overflow flag and a synchronous flush.
- Sits between operand sources (register file or streaming buffers) and the accumulator/activation stages of the neuro-accelerator arithmetic path.

Parameters:
- N, 16, operand/result width in bits (N >= 4).
- PIPE, 2, number of register stages from input to output (PIPE >= 1).
- SAT, 0, 1 = ADD/SUB saturate to signed max/min on overflow; 0 = wrap.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all in-flight beats.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- A  in  N  signed operand A.
- B  in  N  signed operand B.
- opcode  in  3  operation select.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- Y  out  N  signed result.
- co  out  1  carry out (ADD/SUB only).
- ovf  out  1  signed overflow (ADD/SUB only).

Behaviour:
- Opcodes:
  - 000 ADD: Y = A + B.
  - 001 SUB: Y = A - B, computed as A + ~B + 1.
  - 010 AND, 011 OR, 100 XOR.
  - 101 NOT: Y = ~A.
  - 110 SHL: logical shift of A left by B[$clog2(N)-1:0].
  - 111 ASR: arithmetic shift of A right by B[$clog2(N)-1:0].
- co is the carry out of the N-bit adder. For SUB, co = 1 means no borrow. co is 0 for all non-arithmetic opcodes.
- ovf is set when the operand signs make overflow possible and the result sign differs:
  - ADD: A and B have the same sign and the result sign differs from it.
  - SUB: A and B have different signs and the result sign differs from A.
  - ovf is 0 for all other opcodes.
- Saturation (SAT = 1 and ovf = 1):
  - Y = 2^(N-1)-1 if A >= 0, else Y = -2^(N-1).
  - ovf is still reported; co is unaffected.
- Datapath structure:
  - Result, co and ovf are computed combinationally from the accepted inputs and captured in stage 1.
  - Stages 2..PIPE are pure delay registers, each carrying a valid bit.
- Handshake:
  - Stall condition: stall = out_valid & ~out_ready.
  - in_ready = ~stall. in_ready is combinational from out_ready and out_valid.
  - A beat is accepted on a rising edge where in_valid & in_ready.
  - When stall = 1, every stage holds (global enable); no beat is lost or duplicated.
  - When not stalled, each stage advances every cycle. Bubbles (valid = 0) advance like data.
- Latency: an accepted beat appears on out_valid/Y/co/ovf after PIPE rising edges, counting the accepting edge as the first, with no stalls. Each stall cycle adds one cycle.
- Throughput: 1 beat/cycle while out_ready = 1.
- Output stability: while out_valid = 1 and out_ready = 0, Y/co/ovf are held stable.
- Flush:
  - On a rising edge with flush = 1, all stage valid bits clear; out_valid = 0 after that edge.
  - Flush overrides stall and discards any beat presented in the same cycle.
  - Data registers need not clear on flush.
- Reset:
  - rst_n low asynchronously clears all valid bits and data registers.
  - Outputs during and after reset: out_valid = 0, Y = 0, co = 0, ovf = 0.
  - in_ready = 1 during reset.
  - Reset mid-stream discards all in-flight beats.
- PIPE = 1 is a single registered stage with the same handshake rules.

Test Plan:
- ADD, N=16, PIPE=2, SAT=0, A=100, B=-30, out_ready=1 -> out_valid rises 2 edges after acceptance; Y=70, co=1, ovf=0.
- ADD A=32767, B=1 -> SAT=0: Y=-32768, ovf=1, co=0. SAT=1: Y=32767, ovf=1.
- SUB, SAT=1, A=-32768, B=1 -> Y=-32768, ovf=1, co=1. Then ASR with A=-16, B=2 -> Y=-4, co=0, ovf=0.
- Backpressure: stream 4 ADD beats A=i, B=i (i=1..4); hold out_ready=0 for 3 cycles after the first result.
  - Required: in_ready=0 and Y=2 held during the stall.
  - After release: results 2, 4, 6, 8 in order, no drop or duplicate.
- Flush with 2 beats in flight -> out_valid=0 after the flush edge; the next beat after flush emerges with the correct latency.
- Assert rst_n=0 asynchronously between clock edges with beats in flight -> outputs zero immediately; after release, the first accepted beat emerges after PIPE edges.
